// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// FSM state type and requester port indices.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int PORT_ALU = 0;
    localparam int PORT_LSU = 1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Holds the last-grant pointer, which advances
// only when the update strobe marks a completed transfer.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       upd,
    output logic [1:0] grant,
    output logic       last
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                // Tie: the port that did not win most recently goes first.
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= grant[PORT_LSU];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback.
// Define REGFILE_CLEAR_EN to zero x1..x31 after every reset before accepting requests.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]   alu_data_i,
    output logic              alu_ready_o,
    input  logic              lsu_valid_i,
    input  logic [ADDR_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    output logic              lsu_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]   data_o,
    output logic              busy_o
);

    state_t            state_q, state_d;
    logic              run;
    logic              clr_done;
    logic [1:0]        grant;
    logic              last;
    logic              xfer;
    logic [ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

`ifdef REGFILE_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_cnt;

    assign clr_done = (clr_cnt == {ADDR_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= ADDR_W'(1);
        end else if (state_q == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end
`else
    localparam state_t RST_STATE = RUN;
    assign clr_done = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_done) begin
            state_d = RUN;
        end
    end

    always_comb begin
        run = (state_q == RUN);
`ifdef REGFILE_CLEAR_EN
        busy_o = (state_q == CLEAR);
`else
        busy_o = 1'b0;
`endif
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({lsu_valid_i, alu_valid_i}),
        .en    (run),
        .upd   (xfer),
        .grant (grant),
        .last  (last)
    );

    // ready equals grant, so a grant is always a completed transfer.
    assign alu_ready_o = grant[PORT_ALU];
    assign lsu_ready_o = grant[PORT_LSU];
    assign xfer        = |grant;
    assign sel_rd      = grant[PORT_LSU] ? lsu_rd_i   : alu_rd_i;
    assign sel_data    = grant[PORT_LSU] ? lsu_data_i : alu_data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_o   <= 1'b0;
            rd_addr_o <= '0;
            data_o    <= '0;
        end else begin
            wr_en_o <= 1'b0;
`ifdef REGFILE_CLEAR_EN
            if (state_q == CLEAR) begin
                wr_en_o   <= 1'b1;
                rd_addr_o <= clr_cnt;
                data_o    <= '0;
            end else
`endif
            // x0 writes are acknowledged but leave the port idle.
            if (xfer && sel_rd != '0) begin
                wr_en_o   <= 1'b1;
                rd_addr_o <= sel_rd;
                data_o    <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios, then random
// traffic against a behavioural arbitration / register-file model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        alu_ready_o;
    logic        lsu_valid_i = 1'b0;
    logic [4:0]  lsu_rd_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic        lsu_ready_o;
    logic        wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] data_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    int          m_last;
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] rf_m   [32];
    logic [31:0] dut_rf [32];

`ifdef REGFILE_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .alu_ready_o (alu_ready_o),
        .lsu_valid_i (lsu_valid_i),
        .lsu_rd_i    (lsu_rd_i),
        .lsu_data_i  (lsu_data_i),
        .lsu_ready_o (lsu_ready_o),
        .wr_en_o     (wr_en_o),
        .rd_addr_o   (rd_addr_o),
        .data_o      (data_o),
        .busy_o      (busy_o)
    );

    // Register file as seen from the DUT write port.
    always @(posedge clk) begin
        if (wr_en_o) dut_rf[rd_addr_o] <= data_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_wr   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en_o, 1'b0);
        check("rst_addr", rd_addr_o, 5'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_busy", busy_o, BUSY_RST);
        model_reset();
        rst = 1'b0;
    endtask

    // One bus cycle: drive, check ready mid-cycle, advance model, check outputs.
    task automatic run_cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                             input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                             output int g);
        logic [4:0] rd;
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
        @(negedge clk);
        if (av && lv)  g = 1 - m_last;
        else if (av)   g = 0;
        else if (lv)   g = 1;
        else           g = -1;
        check("alu_ready", alu_ready_o, g == 0);
        check("lsu_ready", lsu_ready_o, g == 1);
        @(posedge clk);
        if (m_wr) rf_m[m_addr] = m_data;
        if (g >= 0) begin
            m_last = g;
            rd = (g == 1) ? lrd : ard;
            m_wr = (rd != 5'd0);
            if (m_wr) begin
                m_addr = rd;
                m_data = (g == 1) ? ld : ad;
            end
        end else begin
            m_wr = 1'b0;
        end
        #1;
        check("wr_en", wr_en_o, m_wr);
        check("wr_addr", rd_addr_o, m_addr);
        check("wr_data", data_o, m_data);
    endtask

`ifdef REGFILE_CLEAR_EN
    // Clear sequence after reset release; abort_at>0 pulses reset when that address shows.
    task automatic clear_seq(input int abort_at);
        alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = $urandom;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = $urandom;
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            check("clr_busy", busy_o, 1'b1);
            check("clr_ready", {alu_ready_o, lsu_ready_o}, 2'b00);
            check("clr_wr_en", wr_en_o, k > 0);
            if (k > 0) begin
                check("clr_addr", rd_addr_o, 5'(k));
                check("clr_data", data_o, 32'd0);
            end
            if (abort_at > 0 && k == abort_at) begin
                rst = 1'b1;
                #1;
                check("mid_rst_wr_en", wr_en_o, 1'b0);
                check("mid_rst_addr", rd_addr_o, 5'd0);
                check("mid_rst_data", data_o, 32'd0);
                check("mid_rst_busy", busy_o, 1'b1);
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        @(negedge clk);
        check("clr_end_busy", busy_o, 1'b0);
        check("clr_end_wr_en", wr_en_o, 1'b1);
        check("clr_end_addr", rd_addr_o, 5'd31);
        check("clr_end_data", data_o, 32'd0);
        @(posedge clk);
        #1;
        // Last clear write is still pending on the port.
        m_wr = 1'b1; m_addr = 5'd31; m_data = 32'd0;
    endtask
`endif

    initial begin : main
        int g;
        logic        av, lv;
        logic [4:0]  ard, lrd;
        logic [31:0] ad, ld;

        for (int i = 0; i < 32; i++) begin
            rf_m[i]   = '0;
            dut_rf[i] = '0;
        end
        model_reset();

        do_reset();
`ifdef REGFILE_CLEAR_EN
        clear_seq(12);
        clear_seq(0);
`endif

        // Contention from reset: ALU, LSU, ALU, LSU
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, g);
            check("cont_grant", g, (i % 2 == 0) ? 0 : 1);
        end

        // x0 discard on LSU, then a tie goes to ALU
        run_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, g);
        check("x0_grant", g, 1);
        check("x0_wr_en", wr_en_o, 1'b0);
        run_cycle(1'b1, 5'd1, 32'h33, 1'b1, 5'd2, 32'h44, g);
        check("x0_tie_grant", g, 0);

        // Single port
        run_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);
        run_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, g);
        check("single_addr", rd_addr_o, 5'd5);
        check("single_data", data_o, 32'hDEAD_BEEF);

        // Idle hold
        run_cycle(1'b0, 5'd6, 32'h5555, 1'b0, 5'd6, 32'h6666, g);

        // Same-rd conflict after an ALU grant: LSU first, then ALU
        run_cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, g);
        check("same_rd_first", g, 1);
        run_cycle(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'h0, g);
        check("same_rd_second", g, 0);
        run_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);
        run_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);
        check("same_rd_x7", dut_rf[7], 32'hA);

        // Random traffic; a request holds until acknowledged
        av = 1'b0; lv = 1'b0; ard = '0; lrd = '0; ad = '0; ld = '0;
        for (int i = 0; i < 300; i++) begin
            if (!av && $urandom_range(0, 3) != 0) begin
                av = 1'b1; ard = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!lv && $urandom_range(0, 3) != 0) begin
                lv = 1'b1; lrd = 5'($urandom_range(0, 31)); ld = $urandom;
            end
            run_cycle(av, ard, ad, lv, lrd, ld, g);
            if (g == 0) av = 1'b0;
            if (g == 1) lv = 1'b0;
        end
        run_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);
        run_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rf_x%0d", i), dut_rf[i], rf_m[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
